vga_sink: RTL and testbench
===========================

// Module: vga_sink
// PURPOSE
//  Receiving end of the vga_ctrl pixel interface: samples hsync/vsync/valid/RGB and rebuilds pixel
//  coordinates. Emits frame-buffer write beats (addr = y*640+x) and checks frame/line timing.
//  Sits on the loopback path of the SoC top for self-checking video, and can feed a capture RAM.
// PARAMETERS
//  H_ACTIVE  640  valid pixels per line
//  V_ACTIVE  480  active lines per frame
//  H_TOTAL   800  clocks between hsync falling edges
//  ADDR_W    19   write address width
// PORTS
//  clk        in   1       pixel clock, same clock as vga_ctrl
//  clrn       in   1       asynchronous active-low reset
//  hsync      in   1       horizontal sync, active-low pulse
//  vsync      in   1       vertical sync, active-low pulse
//  valid      in   1       active-video qualifier
//  vga_r/g/b  in   8 each  pixel colour
//  err_clr    in   1       one-cycle pulse: clear sticky error flags
//  wr_en      out  1       write strobe, one beat per accepted pixel
//  wr_addr    out  ADDR_W  (y<<9)+(y<<7)+x
//  wr_data    out  24      {r,g,b}
//  frame_done out  1       one-cycle pulse at every frame boundary after the first
//  locked     out  1       set after 2 consecutive good frames; cleared by any bad frame
//  err_hlen   out  1       sticky: line valid count != H_ACTIVE
//  err_vlen   out  1       sticky: active line count != V_ACTIVE
//  err_hper   out  1       sticky: hsync period != H_TOTAL
//  frame_sum  out  32      per-frame pixel checksum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (clrn=0, async): all outputs 0, counters 0, state SEEK, good-frame count 0.
//  - Stage 0 registers every input each clk. Stage 1 registers wr_*.
//  - Latency: a pixel sampled at edge k appears on wr_* after edge k+1.
//  - Edges come from stage 0 vs. its previous value: vfall = vsync 1->0, hfall = hsync 1->0,
//    vend = valid 1->0.
//  - FSM:
//    SEEK: ignore valid, no writes. On vfall -> VBLANK; this first boundary gives no frame_done.
//    VBLANK: x=y=0. On valid=1 -> ACTIVE, writing that pixel.
//    ACTIVE: on valid=1, if x<H_ACTIVE and y<V_ACTIVE then wr_en=1 and x++.
//      Otherwise the write is suppressed, and err_hlen (x overrun) or err_vlen (y overrun) is set.
//      On vend: if x!=H_ACTIVE then err_hlen and the frame is marked bad; then y++ and x=0.
//    VBLANK or ACTIVE on vfall: evaluate the frame, pulse frame_done, go to VBLANK.
//  - Frame evaluation: good iff y==V_ACTIVE and no hlen/vlen/hper event during the frame.
//    Otherwise err_vlen is set if y!=V_ACTIVE. Good: good-count++ (saturates at 2), and locked=1 at 2.
//    Bad: good-count=0, locked=0.
//  - hsync period: a clock counter restarts on each hfall. If its value at hfall != H_TOTAL-1,
//    set err_hper. The check is skipped for the first hfall after reset or after SEEK.
//  - err_clr and a new error event in the same cycle: the error wins, flag stays 1.
//  - vfall and vend in the same cycle: close the line first, then evaluate the frame.
//  - wr_addr arithmetic is done in ADDR_W bits, with no wrap inside the legal range (max 307199).
//  - clrn mid-frame: back to SEEK immediately; the next vfall resynchronises.
// CONFIGURATION
//  VGA_SINK_CHECKSUM_EN defined:
//    - frame_sum is a 32-bit wrapping sum of {8'h0,r,g,b} over all written pixels.
//    - It is latched on the frame_done cycle; the accumulator clears on vfall.
//  Not defined: frame_sum is tied to 0 and no accumulator logic is built.
// TESTING
//  1. Drive vga_ctrl standard 640x480 timing with pixel = y*640+x for 3 frames.
//     -> wr_addr 0..307199, wr_data matches, frame_done x2, locked=1 after 2nd pulse, no errors.
//  2. One line with 639 valid cycles.
//     -> err_hlen=1, locked=0 at that frame_done, relock after 2 good frames.
//  3. Frame with 481 active lines.
//     -> 481st line gives no wr_en, err_vlen=1; err_clr pulse clears it to 0.
//  4. hsync period 801 on one line -> err_hper=1; other flags unchanged.
//  5. Assert clrn low mid-line 200 -> all outputs 0 at once; no writes until the next vfall.
//  6. CHECKSUM_EN with constant pixel 24'h000001 -> frame_sum=307200 at frame_done; built without it -> 0.

Source files
------------

// File: rtl/vga_sink.sv
// rtl/vga_sink.sv - VGA pixel-interface sink: frame-buffer write beats plus line/frame timing checks
// Optional per-frame pixel checksum when VGA_SINK_CHECKSUM_EN is defined.
module vga_sink #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              valid,
  input  logic [7:0]        vga_r,
  input  logic [7:0]        vga_g,
  input  logic [7:0]        vga_b,
  input  logic              err_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              frame_done,
  output logic              locked,
  output logic              err_hlen,
  output logic              err_vlen,
  output logic              err_hper,
  output logic [31:0]       frame_sum
);

  localparam int XW = $clog2(H_ACTIVE + 1) + 1;
  localparam int YW = $clog2(V_ACTIVE + 1) + 1;
  localparam int HW = $clog2(H_TOTAL + 1) + 1;
  localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);

  localparam logic [1:0] S_SEEK   = 2'd0;
  localparam logic [1:0] S_VBLANK = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic              hs_q, vs_q, val_q, clr_q;
  logic              hs_p_q, vs_p_q, val_p_q;
  logic [23:0]       rgb_q;
  logic [1:0]        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d, y_line;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic              armed_q, armed_d;
  logic              bad_q, bad_d, bad_now, good;
  logic [1:0]        gcnt_q, gcnt_d;
  logic              locked_q, locked_d;
  logic              hlen_q, hlen_d, vlen_q, vlen_d, hper_q, hper_d;
  logic              ev_hlen, ev_vlen, ev_hper;
  logic              we_q, we_d, fd_q, fd_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [23:0]       wdata_q, wdata_d;
  logic              hfall, vfall, vend;

  // Stage 0: every input registered, plus one cycle of history for edge detection
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      val_q   <= 1'b0;
      clr_q   <= 1'b0;
      rgb_q   <= '0;
      hs_p_q  <= 1'b0;
      vs_p_q  <= 1'b0;
      val_p_q <= 1'b0;
    end else begin
      hs_q    <= hsync;
      vs_q    <= vsync;
      val_q   <= valid;
      clr_q   <= err_clr;
      rgb_q   <= {vga_r, vga_g, vga_b};
      hs_p_q  <= hs_q;
      vs_p_q  <= vs_q;
      val_p_q <= val_q;
    end
  end

  assign hfall = hs_p_q & ~hs_q;
  assign vfall = vs_p_q & ~vs_q;
  assign vend  = val_p_q & ~val_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    y_line   = y_q;
    hcnt_d   = hcnt_q;
    armed_d  = armed_q;
    bad_d    = bad_q;
    bad_now  = bad_q;
    good     = 1'b0;
    gcnt_d   = gcnt_q;
    locked_d = locked_q;
    ev_hlen  = 1'b0;
    ev_vlen  = 1'b0;
    ev_hper  = 1'b0;
    we_d     = 1'b0;
    fd_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    // Line period check; the first hfall after leaving SEEK only arms it
    if (state_q == S_SEEK) armed_d = 1'b0;
    if (hfall) begin
      if (armed_q && hcnt_q != H_LAST) ev_hper = 1'b1;
      hcnt_d  = '0;
      armed_d = (state_q != S_SEEK);
    end else if (hcnt_q != {HW{1'b1}}) begin
      hcnt_d = hcnt_q + HW'(1);
    end

    case (state_q)
      S_SEEK: begin
        if (vfall) begin
          state_d = S_VBLANK;
          x_d     = '0;
          y_d     = '0;
          bad_d   = 1'b0;
        end
      end
      S_VBLANK, S_ACTIVE: begin
        // x and y are zero throughout VBLANK, so the first pixel needs no special case
        if (val_q) begin
          state_d = S_ACTIVE;
          if (x_q < X_END && y_q < Y_END) begin
            we_d    = 1'b1;
            waddr_d = ADDR_W'(y_q) * ADDR_W'(H_ACTIVE) + ADDR_W'(x_q);
            wdata_d = rgb_q;
          end else if (x_q >= X_END) begin
            ev_hlen = 1'b1;
          end else begin
            ev_vlen = 1'b1;
          end
          if (x_q != {XW{1'b1}}) x_d = x_q + XW'(1);
        end
        if (vend && state_q == S_ACTIVE) begin
          if (x_q != X_END) ev_hlen = 1'b1;
          if (y_q != {YW{1'b1}}) y_line = y_q + YW'(1);
          y_d = y_line;
          x_d = '0;
        end
        bad_now = bad_q | ev_hlen | ev_vlen | ev_hper;
        bad_d   = bad_now;
        if (vfall) begin
          good = (y_line == Y_END) && !bad_now;
          if (y_line != Y_END) ev_vlen = 1'b1;
          if (good) begin
            if (gcnt_q != 2'd2) gcnt_d = gcnt_q + 2'd1;
            locked_d = (gcnt_q != 2'd0);
          end else begin
            gcnt_d   = 2'd0;
            locked_d = 1'b0;
          end
          fd_d    = 1'b1;
          state_d = S_VBLANK;
          x_d     = '0;
          y_d     = '0;
          bad_d   = 1'b0;
        end
      end
      default: state_d = S_SEEK;
    endcase

    // A new error event beats a simultaneous clear
    hlen_d = (hlen_q & ~clr_q) | ev_hlen;
    vlen_d = (vlen_q & ~clr_q) | ev_vlen;
    hper_d = (hper_q & ~clr_q) | ev_hper;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= S_SEEK;
      x_q      <= '0;
      y_q      <= '0;
      hcnt_q   <= '0;
      armed_q  <= 1'b0;
      bad_q    <= 1'b0;
      gcnt_q   <= 2'd0;
      locked_q <= 1'b0;
      hlen_q   <= 1'b0;
      vlen_q   <= 1'b0;
      hper_q   <= 1'b0;
      we_q     <= 1'b0;
      fd_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hcnt_q   <= hcnt_d;
      armed_q  <= armed_d;
      bad_q    <= bad_d;
      gcnt_q   <= gcnt_d;
      locked_q <= locked_d;
      hlen_q   <= hlen_d;
      vlen_q   <= vlen_d;
      hper_q   <= hper_d;
      we_q     <= we_d;
      fd_q     <= fd_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

`ifdef VGA_SINK_CHECKSUM_EN
  logic [31:0] acc_q, acc_d, sum_q, sum_d;

  always_comb begin
    acc_d = we_d ? acc_q + {8'h00, rgb_q} : acc_q;
    sum_d = fd_d ? acc_d : sum_q;
    if (vfall) acc_d = '0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = 32'd0;
`endif

  assign wr_en      = we_q;
  assign wr_addr    = waddr_q;
  assign wr_data    = wdata_q;
  assign frame_done = fd_q;
  assign locked     = locked_q;
  assign err_hlen   = hlen_q;
  assign err_vlen   = vlen_q;
  assign err_hper   = hper_q;

endmodule

// File: tb/tb_vga_sink.sv
// tb/tb_vga_sink.sv - randomized frame stimulus for vga_sink checked against a frame-level model
// Small geometry keeps runtime low; define VGA_SINK_CHECKSUM_EN to check frame_sum values.
module tb_vga_sink;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int HT = 12;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic          hsync = 1'b1, vsync = 1'b1, valid = 1'b0, err_clr = 1'b0;
  logic [7:0]    vga_r = '0, vga_g = '0, vga_b = '0;
  logic          wr_en, frame_done, locked, err_hlen, err_vlen, err_hper;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [31:0]   frame_sum;

  vga_sink #(.H_ACTIVE(H), .V_ACTIVE(V), .H_TOTAL(HT), .ADDR_W(AW)) dut (
    .clk(clk), .clrn(clrn), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .err_clr(err_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .locked(locked), .err_hlen(err_hlen), .err_vlen(err_vlen), .err_hper(err_hper),
    .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [42:0] exp_q[$];
  logic [42:0] mon_e;
  int          fd_cnt = 0;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e[42:24]));
        check("wr_data", 32'(wr_data), 32'(mon_e[23:0]));
      end
    end
  end

  bit          exp_hlen, exp_vlen, exp_hper, no_wr;
  bit          pend_valid, pend_hlen, pend_vlen, pend_hper;
  int          run = 0, fd_exp = 0;
  logic [31:0] acc, pend_sum, exp_sum;

  task automatic drive_line(input bit vs_low, input int nvalid, input int len, input int y,
                            input bit cpix, input int rst_at, input int clr_at, output bit did_rst);
    did_rst = 1'b0;
    for (int c = 0; c < len; c++) begin
      logic [23:0] px;
      px = cpix ? 24'h000001 : 24'($urandom);
      hsync = (c < 2) ? 1'b0 : 1'b1;
      vsync = vs_low ? 1'b0 : 1'b1;
      valid = (c >= 3 && c < 3 + nvalid);
      {vga_r, vga_g, vga_b} = px;
      err_clr = (c == clr_at);
      if (c == rst_at) begin
        clrn = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_hper", 32'(err_hper), 32'd0);
        check("rst_frame_sum", frame_sum, 32'd0);
        exp_q.delete();
        did_rst = 1'b1;
        no_wr = 1'b1;
      end else if (valid && !no_wr && y >= 0 && y < V && (c - 3) < H) begin
        exp_q.push_back({AW'(y * H + c - 3), px});
        acc = acc + {8'h00, px};
      end
      @(posedge clk);
      #1;
      if (c == rst_at) clrn = 1'b1;
    end
    err_clr = 1'b0;
    valid = 1'b0;
  endtask

  task automatic frame(input int n_act, input int short_y, input int long_y, input bit cpix,
                       input int rst_y, input bit do_clr);
    bit r;
    bit any_rst;
    any_rst = 1'b0;
    no_wr = 1'b0;
    drive_line(1'b1, 0, HT, -1, 1'b0, -1, -1, r);
    if (pend_valid) begin
      fd_exp++;
      if (!pend_hlen && !pend_vlen && !pend_hper) run = (run < 2) ? run + 1 : 2;
      else run = 0;
      exp_hlen |= pend_hlen;
      exp_vlen |= pend_vlen;
      exp_hper |= pend_hper;
`ifdef VGA_SINK_CHECKSUM_EN
      exp_sum = pend_sum;
`else
      exp_sum = 32'd0;
`endif
    end
    check("frame_done_cnt", 32'(fd_cnt), 32'(fd_exp));
    check("locked", 32'(locked), 32'(run == 2));
    check("err_hlen", 32'(err_hlen), 32'(exp_hlen));
    check("err_vlen", 32'(err_vlen), 32'(exp_vlen));
    check("err_hper", 32'(err_hper), 32'(exp_hper));
    check("frame_sum", frame_sum, exp_sum);
    acc = '0;
    drive_line(1'b0, 0, HT, -1, 1'b0, -1, do_clr ? 5 : -1, r);
    if (do_clr) begin
      exp_hlen = 1'b0;
      exp_vlen = 1'b0;
      exp_hper = 1'b0;
      check("clr_err_hlen", 32'(err_hlen), 32'd0);
      check("clr_err_vlen", 32'(err_vlen), 32'd0);
      check("clr_err_hper", 32'(err_hper), 32'd0);
    end
    for (int y = 0; y < n_act; y++) begin
      drive_line(1'b0, (y == short_y) ? H - 1 : H, (y == long_y) ? HT + 1 : HT,
                 any_rst ? -1 : y, cpix, (y == rst_y) ? 6 : -1, -1, r);
      if (r) begin
        any_rst  = 1'b1;
        exp_hlen = 1'b0;
        exp_vlen = 1'b0;
        exp_hper = 1'b0;
        run      = 0;
        exp_sum  = '0;
      end
    end
    drive_line(1'b0, 0, HT, -1, 1'b0, -1, -1, r);
    pend_valid = !any_rst;
    pend_hlen  = short_y >= 0 && short_y < n_act;
    pend_vlen  = n_act != V;
    pend_hper  = long_y >= 0 && long_y < n_act;
    pend_sum   = acc;
  endtask

  initial begin
    exp_hlen = 0; exp_vlen = 0; exp_hper = 0; no_wr = 0;
    pend_valid = 0; pend_hlen = 0; pend_vlen = 0; pend_hper = 0;
    acc = '0; pend_sum = '0; exp_sum = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_errs", 32'({err_hlen, err_vlen, err_hper}), 32'd0);
    check("reset_frame_sum", frame_sum, 32'd0);
    clrn = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) frame(V, -1, -1, 1'b0, -1, 1'b0);
    frame(V, int'($urandom_range(0, V - 1)), -1, 1'b0, -1, 1'b0);
    for (int i = 0; i < 3; i++) frame(V, -1, -1, 1'b0, -1, 1'b0);
    frame(V + 1, -1, -1, 1'b0, -1, 1'b0);
    frame(V, -1, -1, 1'b0, -1, 1'b1);
    frame(V, -1, int'($urandom_range(0, V - 1)), 1'b0, -1, 1'b0);
    frame(V, -1, -1, 1'b1, -1, 1'b0);
    frame(V, -1, -1, 1'b0, -1, 1'b0);
    frame(V, -1, -1, 1'b0, 2, 1'b0);
    for (int i = 0; i < 3; i++) frame(V, -1, -1, 1'b0, -1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      int n, sy, ly;
      n  = V - 1 + int'($urandom_range(0, 2));
      sy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      ly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      frame(n, sy, ly, 1'b0, -1, ($urandom_range(0, 3) == 0));
    end
    frame(V, -1, -1, 1'b0, -1, 1'b0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
